// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction buffer / issue sequencer.
// Imported by the sequencer top and its program memory.
package instr_seq_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // The word count has to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program storage: DEPTH x WIDTH register file with one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset.
module instr_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     CLK,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]         i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [WIDTH-1:0]         o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program buffer and issue sequencer feeding the cpu instruction port: the host
// loads words through a valid/ready handshake, and start replays them in order.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_data,
    output logic                       load_ready,
    input  logic                       start,
    input  logic                       loop_en,
    input  logic                       clear,
    output logic [WIDTH-1:0]           INSTRUCTION,
    output logic                       write_en,
    output logic                       busy,
    output logic                       done,
    output logic [cntWidth(DEPTH)-1:0] count
);

    localparam int CW = cntWidth(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    seq_state_t       r_state;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_instr;
    logic             r_writeEn;

    logic             w_startOk;
    logic             w_atEnd;
    logic             w_wrEn;
    logic [AW-1:0]    w_rdAddr;
    logic [WIDTH-1:0] w_rdData;

    assign w_startOk  = start && (r_count != '0);
    assign w_atEnd    = (r_ptr == r_count);
    assign load_ready = (r_state == IDLE) && (r_count < FULL);

    // Start and clear both take precedence over a load presented on the same edge.
    assign w_wrEn   = load_valid && load_ready && !clear && !w_startOk;
    assign w_rdAddr = (r_state == RUN && !w_atEnd) ? r_ptr[AW-1:0] : '0;

    instr_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .CLK      (CLK),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_count[AW-1:0]),
        .i_wrData (load_data),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_ptr     <= '0;
            r_instr   <= '0;
            r_writeEn <= 1'b0;
        end else if (clear) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_ptr     <= '0;
            r_writeEn <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_startOk) begin
                        r_instr   <= w_rdData;
                        r_writeEn <= 1'b1;
                        r_ptr     <= CW'(1);
                        r_state   <= RUN;
                    end else if (w_wrEn) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                RUN: begin
                    // loop_en only matters at the wrap point; mid-program it is ignored.
                    if (w_atEnd && loop_en) begin
                        r_instr <= w_rdData;
                        r_ptr   <= CW'(1);
                    end else if (w_atEnd) begin
                        r_writeEn <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_instr <= w_rdData;
                        r_ptr   <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_writeEn <= 1'b0;
                end
            endcase
        end
    end

    assign INSTRUCTION = r_instr;
    assign write_en    = r_writeEn;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign count       = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer with hand-written sequences
// for buffer overflow and asynchronous reset in the middle of a run.
module tb_instr_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       load_valid;
    logic [8:0] load_data;
    logic       load_ready;
    logic       start;
    logic       loop_en;
    logic       clear;
    logic [8:0] INSTRUCTION;
    logic       write_en;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       lv;
        logic [8:0] ld;
        logic       st;
        logic       lp;
        logic       clr;
        logic       eWe;
        logic [8:0] eIns;
        logic       chkIns;
        logic       eBusy;
        logic       eDone;
        logic [3:0] eCnt;
        logic       eRdy;
    } vec_t;

    vec_t tbl[$];

    always #5 CLK = ~CLK;

    instr_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .start       (start),
        .loop_en     (loop_en),
        .clear       (clear),
        .INSTRUCTION (INSTRUCTION),
        .write_en    (write_en),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, " write_en"}, 32'(write_en), 32'(v.eWe));
        if (v.chkIns) checkOutput({tag, " INSTRUCTION"}, 32'(INSTRUCTION), 32'(v.eIns));
        checkOutput({tag, " busy"}, 32'(busy), 32'(v.eBusy));
        checkOutput({tag, " done"}, 32'(done), 32'(v.eDone));
        checkOutput({tag, " count"}, 32'(count), 32'(v.eCnt));
        checkOutput({tag, " load_ready"}, 32'(load_ready), 32'(v.eRdy));
    endtask

    task automatic driveIdle();
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        loop_en    = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        load_valid = v.lv;
        load_data  = v.ld;
        start      = v.st;
        loop_en    = v.lp;
        clear      = v.clr;
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic lv, input logic [8:0] ld, input logic st,
                                input logic lp, input logic clr, input logic eWe,
                                input logic [8:0] eIns, input logic chkIns, input logic eBusy,
                                input logic eDone, input logic [3:0] eCnt, input logic eRdy);
        vec_t v;
        v = '{lv, ld, st, lp, clr, eWe, eIns, chkIns, eBusy, eDone, eCnt, eRdy};
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [8:0] words [8];

        // Directed table: three-word replay, clear, empty start, looping, clear mid-run.
        tbl.push_back(mk(1, 9'h001, 0, 0, 0,  0, 9'h000, 1,  0, 0, 4'd1, 1));
        tbl.push_back(mk(1, 9'h002, 0, 0, 0,  0, 9'h000, 1,  0, 0, 4'd2, 1));
        tbl.push_back(mk(1, 9'h004, 0, 0, 0,  0, 9'h000, 1,  0, 0, 4'd3, 1));
        tbl.push_back(mk(0, 9'h000, 1, 0, 0,  1, 9'h001, 1,  1, 0, 4'd3, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  1, 9'h002, 1,  1, 0, 4'd3, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  1, 9'h004, 1,  1, 0, 4'd3, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  0, 9'h004, 1,  0, 1, 4'd3, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  0, 9'h004, 1,  0, 1, 4'd3, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 1,  0, 9'h000, 0,  0, 0, 4'd0, 1));
        tbl.push_back(mk(0, 9'h000, 1, 0, 0,  0, 9'h000, 0,  0, 0, 4'd0, 1));
        tbl.push_back(mk(1, 9'h0A0, 0, 1, 0,  0, 9'h000, 0,  0, 0, 4'd1, 1));
        tbl.push_back(mk(1, 9'h0B0, 0, 1, 0,  0, 9'h000, 0,  0, 0, 4'd2, 1));
        tbl.push_back(mk(1, 9'h155, 1, 1, 0,  1, 9'h0A0, 1,  1, 0, 4'd2, 0));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0, 9'h000, 0, 1, 0,  1, (k % 2) ? 9'h0B0 : 9'h0A0, 1,  1, 0, 4'd2, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  1, 9'h0B0, 1,  1, 0, 4'd2, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  0, 9'h0B0, 1,  0, 1, 4'd2, 0));
        tbl.push_back(mk(0, 9'h000, 1, 0, 0,  1, 9'h0A0, 1,  1, 0, 4'd2, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 0,  1, 9'h0B0, 1,  1, 0, 4'd2, 0));
        tbl.push_back(mk(0, 9'h000, 0, 0, 1,  0, 9'h000, 0,  0, 0, 4'd0, 1));

        driveIdle();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkAll("reset", mk(0, 0, 0, 0, 0,  0, 9'h000, 1,  0, 0, 4'd0, 1));
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkAll($sformatf("row%0d", i), tbl[i]);
        end

        // Fill all eight slots, then try to push a ninth word that must be dropped.
        for (int i = 0; i < 8; i++) begin
            words[i] = 9'(9'h011 * (i + 1) + 3);
            applyStimulus(mk(1, words[i], 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
            checkOutput($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            checkOutput($sformatf("fill%0d load_ready", i), 32'(load_ready), 32'(i < 7));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mk(1, 9'h1FF, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
            checkOutput("overflow count", 32'(count), 32'd8);
            checkOutput("overflow load_ready", 32'(load_ready), 32'd0);
        end
        applyStimulus(mk(0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("replay%0d write_en", i), 32'(write_en), 32'd1);
            checkOutput($sformatf("replay%0d INSTRUCTION", i), 32'(INSTRUCTION), 32'(words[i]));
            applyStimulus(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        end
        checkOutput("replay end write_en", 32'(write_en), 32'd0);
        checkOutput("replay end done", 32'(done), 32'd1);

        // Restart from DONE, then hit RESET between clock edges in the middle of the run.
        applyStimulus(mk(0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        checkOutput("prereset busy", 32'(busy), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("async reset write_en", 32'(write_en), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset INSTRUCTION", 32'(INSTRUCTION), 32'd0);
        checkOutput("async reset count", 32'(count), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        applyStimulus(mk(1, 9'h0C3, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        checkOutput("reload count", 32'(count), 32'd1);
        applyStimulus(mk(0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        checkOutput("single write_en", 32'(write_en), 32'd1);
        checkOutput("single INSTRUCTION", 32'(INSTRUCTION), 32'h0C3);
        applyStimulus(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        checkOutput("single end write_en", 32'(write_en), 32'd0);
        checkOutput("single end done", 32'(done), 32'd1);
        checkOutput("single end INSTRUCTION", 32'(INSTRUCTION), 32'h0C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program buffer and issue sequencer that drives the `cpu` core's instruction port. A host loads up to DEPTH 9-bit instruction words through a valid/ready handshake. On `start`, the block replays the words in order on `INSTRUCTION` with `write_en` asserted, optionally looping. It sits between the top-level pin interface and `cpu`, and is the producer side of the `INSTRUCTION`/`write_en` interface.

## Interface
- `DEPTH`, 8: number of program words stored (power of two, ≥2).
- `WIDTH`, 9: instruction word width; matches `cpu.INSTRUCTION`.

- `CLK` input 1: clock, rising-edge.
- `RESET` input 1: asynchronous, active-high reset.
- `load_valid` input 1: host presents a program word.
- `load_data` input WIDTH: program word.
- `load_ready` output 1: buffer accepts a word this cycle.
- `start` input 1: begin issuing the stored program.
- `loop_en` input 1: at end of program, wrap to word 0 instead of stopping.
- `clear` input 1: synchronous abort; empties the buffer.
- `INSTRUCTION` output WIDTH: registered instruction word to `cpu`.
- `write_en` output 1: registered; `INSTRUCTION` is valid this cycle.
- `busy` output 1: state is RUN.
- `done` output 1: state is DONE.
- `count` output clog2(DEPTH+1): number of stored words.

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - State IDLE.
  - `count`, read pointer, `INSTRUCTION`, `write_en`, `busy`, `done` all 0.
  - Memory contents are not reset.
- IDLE:
  - `load_ready = (count < DEPTH)`.
  - A word is written on an edge where `load_valid && load_ready`: `mem[count] <= load_data`, `count++`.
  - `load_valid` while full is dropped with no state change.
- IDLE, `start && count != 0`:
  - `INSTRUCTION <= mem[0]`, `write_en <= 1`, pointer <= 1, state → RUN.
  - If `load_valid` is also high on that edge, the load is ignored; start wins.
- IDLE, `start && count == 0`: ignored; state stays IDLE.
- RUN, on each edge:
  - If pointer == count and `loop_en` = 1: emit `mem[0]`, pointer <= 1.
  - If pointer == count and `loop_en` = 0: `write_en <= 0`, state → DONE.
  - Otherwise: emit `mem[pointer]`, pointer++, `write_en` stays 1.
  - `load_ready = 0`; `start` is ignored.
- DONE:
  - `write_en = 0`; `INSTRUCTION` holds the last issued word.
  - `start` replays the program exactly as from IDLE.
  - `load_ready = 0`.
- `clear`, in any state:
  - `count <= 0`, pointer <= 0, `write_en <= 0`, state → IDLE.
  - Takes priority over `start` and load.
- `loop_en` is sampled only at the wrap decision.
- `count` saturates at DEPTH; the pointer never exceeds `count`.

## Timing
- `start` sampled at edge T: `write_en` is high from T to T+N, i.e. exactly N = `count` consecutive cycles, each carrying `mem[0..N-1]` in order.
- Without loop: `done` rises at edge T+N; `write_en` falls on the same edge.
- With loop: the word sequence is gapless, e.g. for N=3: w0 w1 w2 w0 w1 …
- N=1 with loop: `write_en` stays high continuously with `mem[0]`.
- Load: 1 word per cycle at full throughput; `load_ready` is combinational from state and `count`.
- `clear` at edge C: `write_en` = 0 and `load_ready` = 1 from edge C onward.
- RESET mid-RUN: all outputs drop to 0 asynchronously; the buffer is logically empty after reset.

## Structure
- Package `instr_seq_pkg`:
  - State enum (IDLE/RUN/DONE).
  - Default DEPTH/WIDTH constants.
  - Count-width function.
- Sub-module `instr_mem`:
  - DEPTH×WIDTH register file, one synchronous write port, one asynchronous read port.
  - No reset.
- Top level:
  - FSM, write pointer/`count`, read pointer, output registers.

## Test plan
- Reset, then load 0x001, 0x002, 0x004 and pulse `start` with `loop_en`=0 → `write_en` high for exactly 3 cycles carrying 0x001, 0x002, 0x004; then `done`=1 and `write_en`=0.
- Load 8 words, then hold `load_valid` with 0x1FF → `load_ready`=0, `count`=8, the 9th word is dropped; replay shows the original 8 words.
- `loop_en`=1 with 2 words 0x0A0, 0x0B0 → `write_en` held high with alternating 0x0A0/0x0B0 for 10 cycles; deassert `loop_en` → stops after the next 0x0B0 and enters DONE.
- Pulse `start` with `count`=0 → remains IDLE, `write_en`=0. Then `start` and `load_valid` on the same edge with `count`=2 → RUN, `count` stays 2.
- Assert `clear` during RUN after 2 words issued → `write_en`=0 the next cycle, state IDLE, `count`=0, `load_ready`=1.
- Assert RESET asynchronously mid-RUN → `write_en`, `busy`, `done`, `INSTRUCTION` go to 0 immediately. Then a 1-word reload and `start` → a single `write_en` pulse.
